wb_stage_reg: RTL and testbench

- Parametrised MEM/WB pipeline boundary register; generalises the single-lane MEM/WB latch.
- Sits between the memory stage and write-back.
- Carries LANES independent GPR write-back lanes plus one HI/LO write.
- Adds a valid bit, an exception flush, a correct 1-bit HI/LO enable, and saturating bubble/hold performance counters with synchronous clear.

---
 rtl/wb_stage_reg.sv | 131 +++++++++++++
 tb/tb_wb_stage_reg.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_reg.sv
// wb_stage_reg: MEM/WB pipeline boundary register.
// Carries LANES independent GPR write-back lanes plus one HI/LO write into the
// write-back stage. One control decision applies to every lane at each edge:
// reset > flush bubble > stall bubble > load > hold. Two saturating counters
// record the bubble and hold cycles and have their own synchronous clear.
//
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   stall        per-stage stall vector; bit STAGE_IDX is MEM, STAGE_IDX+1 is WB
//   flush        exception flush: kills incoming and held contents
//   cnt_clr      synchronous clear of both performance counters
//   in_*         MEM-stage results (lane k at [k*W +: W])
//   out_*        registered WB copies, 1-cycle latency
//   bubble_cnt   saturating count of bubble cycles
//   hold_cnt     saturating count of hold cycles
module wb_stage_reg #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned LANES     = 1,
    parameter int unsigned STALL_W   = 6,
    parameter int unsigned STAGE_IDX = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [STALL_W-1:0]       stall,
    input  logic                     flush,
    input  logic                     cnt_clr,
    input  logic                     in_valid,
    input  logic [LANES*ADDR_W-1:0]  in_wd,
    input  logic [LANES-1:0]         in_wreg,
    input  logic [LANES*DATA_W-1:0]  in_wdata,
    input  logic [DATA_W-1:0]        in_hi,
    input  logic [DATA_W-1:0]        in_lo,
    input  logic                     in_whilo,
    output logic                     out_valid,
    output logic [LANES*ADDR_W-1:0]  out_wd,
    output logic [LANES-1:0]         out_wreg,
    output logic [LANES*DATA_W-1:0]  out_wdata,
    output logic [DATA_W-1:0]        out_hi,
    output logic [DATA_W-1:0]        out_lo,
    output logic                     out_whilo,
    output logic [CNT_W-1:0]         bubble_cnt,
    output logic [CNT_W-1:0]         hold_cnt
);

    localparam int unsigned WD_W    = LANES * ADDR_W;
    localparam int unsigned WDATA_W = LANES * DATA_W;

    // Reject parameter sets the stall decode or lane packing cannot support.
    generate
        if (LANES < 1 || LANES > 4 || (STAGE_IDX + 2) > STALL_W) begin : g_bad_params
            $error("wb_stage_reg: illegal LANES or STAGE_IDX/STALL_W combination");
        end
    endgenerate

    logic                 r_valid;
    logic [WD_W-1:0]      r_wd;
    logic [LANES-1:0]     r_wreg;
    logic [WDATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]    r_hi;
    logic [DATA_W-1:0]    r_lo;
    logic                 r_whilo;
    logic [CNT_W-1:0]     r_bubble_cnt;
    logic [CNT_W-1:0]     r_hold_cnt;

    logic                 w_s_up;
    logic                 w_s_dn;
    logic                 w_bubble;
    logic                 w_hold;
    logic                 w_load;
    logic                 w_unused_stall;

    // Only two stall bits matter here; fold the rest so they are consumed.
    assign w_unused_stall = ^stall;

    // Control decision shared by all lanes.
    assign w_s_up   = stall[STAGE_IDX];
    assign w_s_dn   = stall[STAGE_IDX + 1];
    assign w_bubble = flush | (w_s_up & ~w_s_dn);
    assign w_hold   = ~flush & w_s_up & w_s_dn;
    assign w_load   = ~flush & ~w_s_up;

    // Datapath register. Bubble writes NOP (register 0, no enables).
    always_ff @(posedge clk) begin
        if (rst || w_bubble) begin
            r_valid <= 1'b0;
            r_wd    <= '0;
            r_wreg  <= '0;
            r_wdata <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_whilo <= 1'b0;
        end else if (w_load) begin
            // An invalid slot still copies address/data but can never write.
            r_valid <= in_valid;
            r_wd    <= in_wd;
            r_wreg  <= in_valid ? in_wreg : '0;
            r_wdata <= in_wdata;
            r_hi    <= in_hi;
            r_lo    <= in_lo;
            r_whilo <= in_valid & in_whilo;
        end
    end

    // Saturating performance counters; clear beats increment.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            r_bubble_cnt <= '0;
            r_hold_cnt   <= '0;
        end else begin
            if (w_bubble && (r_bubble_cnt != {CNT_W{1'b1}})) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            end
            if (w_hold && (r_hold_cnt != {CNT_W{1'b1}})) begin
                r_hold_cnt <= r_hold_cnt + CNT_W'(1);
            end
        end
    end

    assign out_valid  = r_valid;
    assign out_wd     = r_wd;
    assign out_wreg   = r_wreg;
    assign out_wdata  = r_wdata;
    assign out_hi     = r_hi;
    assign out_lo     = r_lo;
    assign out_whilo  = r_whilo;
    assign bubble_cnt = r_bubble_cnt;
    assign hold_cnt   = r_hold_cnt;

endmodule

// File: tb/tb_wb_stage_reg.sv
// Testbench for wb_stage_reg: directed scenarios plus a randomized run checked
// against a cycle-level reference model of the stage's priority rules.
module tb_wb_stage_reg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ADDR_W    = 5;
    localparam int unsigned LANES     = 2;
    localparam int unsigned STALL_W   = 6;
    localparam int unsigned STAGE_IDX = 4;
    localparam int unsigned CNT_W     = 4;
    localparam int          CNT_MAX   = (1 << CNT_W) - 1;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [STALL_W-1:0]       stall;
    logic                     flush;
    logic                     cnt_clr;
    logic                     in_valid;
    logic [LANES*ADDR_W-1:0]  in_wd;
    logic [LANES-1:0]         in_wreg;
    logic [LANES*DATA_W-1:0]  in_wdata;
    logic [DATA_W-1:0]        in_hi;
    logic [DATA_W-1:0]        in_lo;
    logic                     in_whilo;
    logic                     out_valid;
    logic [LANES*ADDR_W-1:0]  out_wd;
    logic [LANES-1:0]         out_wreg;
    logic [LANES*DATA_W-1:0]  out_wdata;
    logic [DATA_W-1:0]        out_hi;
    logic [DATA_W-1:0]        out_lo;
    logic                     out_whilo;
    logic [CNT_W-1:0]         bubble_cnt;
    logic [CNT_W-1:0]         hold_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic                     m_valid;
    logic [LANES*ADDR_W-1:0]  m_wd;
    logic [LANES-1:0]         m_wreg;
    logic [LANES*DATA_W-1:0]  m_wdata;
    logic [DATA_W-1:0]        m_hi;
    logic [DATA_W-1:0]        m_lo;
    logic                     m_whilo;
    int                       m_bubbles;
    int                       m_holds;

    wb_stage_reg #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANES(LANES),
        .STALL_W(STALL_W), .STAGE_IDX(STAGE_IDX), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .in_valid(in_valid), .in_wd(in_wd), .in_wreg(in_wreg), .in_wdata(in_wdata),
        .in_hi(in_hi), .in_lo(in_lo), .in_whilo(in_whilo),
        .out_valid(out_valid), .out_wd(out_wd), .out_wreg(out_wreg),
        .out_wdata(out_wdata), .out_hi(out_hi), .out_lo(out_lo),
        .out_whilo(out_whilo), .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt)
    );

    always #5 clk = ~clk;

    // Apply one edge of the specified behaviour to the model.
    task automatic model_step();
        bit s_up, s_dn, is_bubble, is_hold;
        s_up = stall[STAGE_IDX];
        s_dn = stall[STAGE_IDX+1];
        is_bubble = flush || (s_up && !s_dn);
        is_hold   = !flush && s_up && s_dn;
        if (rst) begin
            m_valid = 0; m_wd = '0; m_wreg = '0; m_wdata = '0;
            m_hi = '0; m_lo = '0; m_whilo = 0;
            m_bubbles = 0; m_holds = 0;
        end else begin
            if (is_bubble) begin
                m_valid = 0; m_wd = '0; m_wreg = '0; m_wdata = '0;
                m_hi = '0; m_lo = '0; m_whilo = 0;
            end else if (!is_hold) begin
                m_valid = in_valid;
                m_wd    = in_wd;
                m_wreg  = in_valid ? in_wreg : '0;
                m_wdata = in_wdata;
                m_hi    = in_hi;
                m_lo    = in_lo;
                m_whilo = in_valid ? in_whilo : 1'b0;
            end
            if (cnt_clr) begin
                m_bubbles = 0; m_holds = 0;
            end else if (is_bubble) begin
                m_bubbles = (m_bubbles < CNT_MAX) ? m_bubbles + 1 : CNT_MAX;
            end else if (is_hold) begin
                m_holds = (m_holds < CNT_MAX) ? m_holds + 1 : CNT_MAX;
            end
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        rst = 0; stall = '0; flush = 0; cnt_clr = 0;
        in_valid = 0; in_wd = '0; in_wreg = '0; in_wdata = '0;
        in_hi = '0; in_lo = '0; in_whilo = 0;
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1; in_valid = 1; in_wreg = '1; in_wdata = '1; in_whilo = 1; in_hi = '1;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if ({out_valid, out_wd, out_wreg, out_wdata, out_hi, out_lo, out_whilo,
                 bubble_cnt, hold_cnt} !== '0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: valid=%b wdata=%h hi=%h bcnt=%0d hcnt=%0d want all 0",
                         c, out_valid, out_wdata, out_hi, bubble_cnt, hold_cnt);
            end
        end
    endtask

    task automatic test_load();
        set_idle();
        in_valid = 1; in_wd = {5'd0, 5'd3}; in_wreg = 2'b01;
        in_wdata = {32'h0, 32'hDEADBEEF};
        tick();
        checks++;
        if (out_wd[4:0] !== 5'd3 || out_wreg[0] !== 1'b1 ||
            out_wdata[31:0] !== 32'hDEADBEEF || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL load: wd=%0d wreg=%b wdata=%h valid=%b want 3 1 deadbeef 1",
                     out_wd[4:0], out_wreg[0], out_wdata[31:0], out_valid);
        end
    endtask

    task automatic test_bubble();
        stall = 6'b011111;
        for (int c = 0; c < 3; c++) begin
            in_wdata = {$urandom, $urandom};
            tick();
            checks++;
            if (out_valid !== 1'b0 || out_wdata !== '0 || out_wd !== '0 || out_wreg !== '0) begin
                errors++;
                $display("FAIL bubble_clear cycle %0d: valid=%b wdata=%h wd=%h wreg=%b want 0",
                         c, out_valid, out_wdata, out_wd, out_wreg);
            end
        end
        checks++;
        if (bubble_cnt !== 4'd3 || hold_cnt !== 4'd0) begin
            errors++;
            $display("FAIL bubble_count: bubble=%0d hold=%0d want 3 0", bubble_cnt, hold_cnt);
        end
    endtask

    task automatic test_hold();
        stall = '0; in_valid = 1; in_wdata = {32'h0, 32'h12345678};
        tick();
        stall = 6'b111111;
        for (int c = 0; c < 4; c++) begin
            in_wdata = {$urandom, $urandom};
            tick();
            checks++;
            if (out_wdata[31:0] !== 32'h12345678 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL hold_data cycle %0d: wdata=%h valid=%b want 12345678 1",
                         c, out_wdata[31:0], out_valid);
            end
        end
        checks++;
        if (hold_cnt !== 4'd4 || bubble_cnt !== 4'd3) begin
            errors++;
            $display("FAIL hold_count: hold=%0d bubble=%0d want 4 3", hold_cnt, bubble_cnt);
        end
    endtask

    task automatic test_flush();
        stall = '0; in_valid = 1; in_whilo = 1; in_hi = 32'h1; flush = 1;
        tick();
        flush = 0;
        checks++;
        if (out_whilo !== 1'b0 || out_hi !== '0 || out_valid !== 1'b0 || bubble_cnt !== 4'd4) begin
            errors++;
            $display("FAIL flush: whilo=%b hi=%h valid=%b bubble=%0d want 0 0 0 4",
                     out_whilo, out_hi, out_valid, bubble_cnt);
        end
        // Flush while both stages stall must still bubble.
        stall = '0; in_valid = 1; in_whilo = 1; in_hi = 32'hABCD; tick();
        stall = 6'b111111; flush = 1; tick();
        flush = 0;
        checks++;
        if (out_valid !== 1'b0 || out_hi !== '0 || bubble_cnt !== 4'd5) begin
            errors++;
            $display("FAIL flush_stalled: valid=%b hi=%h bubble=%0d want 0 0 5",
                     out_valid, out_hi, bubble_cnt);
        end
    endtask

    task automatic test_multilane();
        set_idle();
        in_wd = {5'd9, 5'd7}; in_wreg = 2'b11; in_valid = 0; in_whilo = 1;
        tick();
        checks++;
        if (out_wd !== {5'd9, 5'd7} || out_wreg !== 2'b00 || out_whilo !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL multilane_gate: wd=%h wreg=%b whilo=%b valid=%b want 127 00 0 0",
                     out_wd, out_wreg, out_whilo, out_valid);
        end
    endtask

    task automatic test_saturation();
        int exp_hold;
        exp_hold = int'(hold_cnt);
        set_idle();
        stall = 6'b111111;
        for (int c = 0; c < 20; c++) begin
            tick();
            exp_hold = (exp_hold < CNT_MAX) ? exp_hold + 1 : CNT_MAX;
            checks++;
            if (int'(hold_cnt) != exp_hold) begin
                errors++;
                $display("FAIL hold_saturate cycle %0d: hold=%0d want %0d", c, hold_cnt, exp_hold);
            end
        end
        cnt_clr = 1;
        tick();
        cnt_clr = 0;
        checks++;
        if (hold_cnt !== '0 || bubble_cnt !== '0) begin
            errors++;
            $display("FAIL cnt_clear: hold=%0d bubble=%0d want 0 0", hold_cnt, bubble_cnt);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst      = ($urandom_range(0, 49) == 0);
            flush    = ($urandom_range(0, 9) == 0);
            cnt_clr  = ($urandom_range(0, 29) == 0);
            stall    = STALL_W'($urandom);
            in_valid = $urandom_range(0, 1) == 1;
            in_wd    = (LANES*ADDR_W)'($urandom);
            in_wreg  = LANES'($urandom);
            in_wdata = {$urandom, $urandom};
            in_hi    = $urandom;
            in_lo    = $urandom;
            in_whilo = $urandom_range(0, 1) == 1;
            tick();
            checks++;
            if (out_valid !== m_valid || out_wd !== m_wd || out_wreg !== m_wreg ||
                out_wdata !== m_wdata || out_hi !== m_hi || out_lo !== m_lo ||
                out_whilo !== m_whilo || int'(bubble_cnt) != m_bubbles ||
                int'(hold_cnt) != m_holds) begin
                errors++;
                $display("FAIL random cycle %0d: got v=%b wd=%h wr=%b wdat=%h hi=%h lo=%h whl=%b bc=%0d hc=%0d want v=%b wd=%h wr=%b wdat=%h hi=%h lo=%h whl=%b bc=%0d hc=%0d",
                         c, out_valid, out_wd, out_wreg, out_wdata, out_hi, out_lo, out_whilo,
                         bubble_cnt, hold_cnt, m_valid, m_wd, m_wreg, m_wdata, m_hi, m_lo,
                         m_whilo, m_bubbles, m_holds);
            end
        end
    endtask

    initial begin
        set_idle();
        test_reset();
        test_load();
        test_bubble();
        test_hold();
        test_flush();
        test_multilane();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
